// File: rtl/imem_pkg.sv
// Shared definitions for the burst instruction memory: FSM encoding and default sizes.
package imem_pkg;

  localparam int unsigned DefDw = 16;
  localparam int unsigned DefAw = 14;
  localparam int unsigned DefLw = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StClear = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_array.sv
// Single-port storage array: active-low chip/write enables, registered read data.
module imem_array #(
  parameter int unsigned DW = imem_pkg::DefDw,
  parameter int unsigned AW = imem_pkg::DefAw
) (
  input  logic          clk_i,
  input  logic          cen_i,
  input  logic          wen_i,
  input  logic [AW-1:0] a_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] q_q;

  // Contents and read register are deliberately unreset.
  always_ff @(posedge clk_i) begin
    if (!cen_i) begin
      if (!wen_i) begin
        mem_q[a_i] <= d_i;
      end else begin
        q_q <= mem_q[a_i];
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/imem_burst.sv
// Burst-read / single-write front end for imem_array, with a full-array zero-fill.
module imem_burst
  import imem_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned AW = DefAw,
  parameter int unsigned LW = DefLw
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_wen_i,
  input  logic [AW-1:0] req_a_i,
  input  logic [DW-1:0] req_d_i,
  input  logic [LW-1:0] req_len_i,
  input  logic          clr_start_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_q_o,
  output logic          rsp_last_o,
  output logic          busy_o
);

  imem_state_e   state_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] beat_q;
  logic [LW-1:0] len_q;
  logic          rsp_valid_q;
  logic          rsp_last_q;
  logic [DW-1:0] hold_q;

  logic          accept;
  logic [LW-1:0] len_eff;
  logic [LW-1:0] beat_nxt;

  logic          arr_cen;
  logic          arr_wen;
  logic [AW-1:0] arr_a;
  logic [DW-1:0] arr_d;
  logic [DW-1:0] arr_q;

  assign req_ready_o = (state_q == StIdle) && !clr_start_i;
  assign accept      = req_valid_i && req_ready_o;
  assign len_eff     = (req_len_i == '0) ? LW'(1) : req_len_i;
  assign beat_nxt    = beat_q + LW'(1);

  // Array port steering: the first read beat is issued on the accepting edge so
  // that beat 0 appears one cycle later; later beats are prefetched from addr_q.
  always_comb begin
    arr_cen = 1'b1;
    arr_wen = 1'b1;
    arr_a   = addr_q;
    arr_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          arr_cen = 1'b0;
          arr_wen = req_wen_i;
          arr_a   = req_a_i;
          arr_d   = req_d_i;
        end
      end
      StRead: begin
        if (!rsp_last_q) begin
          arr_cen = 1'b0;
        end
      end
      StClear: begin
        arr_cen = 1'b0;
        arr_wen = 1'b0;
      end
      default: ;
    endcase
  end

  // Control FSM with registered response flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      beat_q      <= '0;
      len_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clr_start_i) begin
            state_q <= StClear;
            addr_q  <= '0;
          end else if (accept && req_wen_i) begin
            state_q     <= StRead;
            addr_q      <= req_a_i + AW'(1);
            beat_q      <= '0;
            len_q       <= len_eff;
            rsp_valid_q <= 1'b1;
            rsp_last_q  <= (len_eff == LW'(1));
          end
        end
        StRead: begin
          if (rsp_last_q) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
          end else begin
            addr_q     <= addr_q + AW'(1);
            beat_q     <= beat_nxt;
            rsp_last_q <= (beat_nxt == len_q - LW'(1));
          end
        end
        StClear: begin
          addr_q <= addr_q + AW'(1);
          if (addr_q == '1) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Keep the last delivered beat visible once the burst ends.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
    end else if (rsp_valid_q) begin
      hold_q <= arr_q;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_last_o  = rsp_last_q;
  assign rsp_q_o     = rsp_valid_q ? arr_q : hold_q;
  assign busy_o      = (state_q == StRead) || (state_q == StClear);

  imem_array #(
    .DW (DW),
    .AW (AW)
  ) u_array (
    .clk_i (clk_i),
    .cen_i (arr_cen),
    .wen_i (arr_wen),
    .a_i   (arr_a),
    .d_i   (arr_d),
    .q_o   (arr_q)
  );

endmodule

// File: tb/tb_imem_burst.sv
// Directed self-checking bench for imem_burst with hand-computed expectations.
module tb_imem_burst;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 14;
  localparam int unsigned LW = 5;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wen;
  logic [AW-1:0] req_a;
  logic [DW-1:0] req_d;
  logic [LW-1:0] req_len;
  logic          clr_start;
  logic          rsp_valid;
  logic [DW-1:0] rsp_q;
  logic          rsp_last;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  imem_burst #(
    .DW (DW),
    .AW (AW),
    .LW (LW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_wen_i   (req_wen),
    .req_a_i     (req_a),
    .req_d_i     (req_d),
    .req_len_i   (req_len),
    .clr_start_i (clr_start),
    .rsp_valid_o (rsp_valid),
    .rsp_q_o     (rsp_q),
    .rsp_last_o  (rsp_last),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_a     = a;
    req_d     = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wen = 1'b1;
  endtask

  // Issues a read and checks every beat, then that the response stream stops.
  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [LW-1:0] len,
                         input logic [DW-1:0] exp[], input int n);
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_a     = a;
    req_len   = len;
    #1 check({tag, " ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check($sformatf("%s valid[%0d]", tag, k), 32'(rsp_valid), 32'd1);
      check($sformatf("%s q[%0d]", tag, k), 32'(rsp_q), 32'(exp[k]));
      check($sformatf("%s last[%0d]", tag, k), 32'(rsp_last), (k == n - 1) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check({tag, " valid after"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] exp[];
    int cnt;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b1;
    req_a     = '0;
    req_d     = '0;
    req_len   = '0;
    clr_start = 1'b0;

    // Reset state
    #12;
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst valid", 32'(rsp_valid), 32'd0);
    check("rst last", 32'(rsp_last), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst q", 32'(rsp_q), 32'd0);
    #11 rst_n = 1'b1;

    // Single beat
    do_write(14'd1, 16'd350);
    exp = new[1];
    exp[0] = 16'd350;
    do_read("single", 14'd1, 5'd1, exp, 1);

    // Four-beat burst
    for (int i = 0; i < 4; i++) do_write(14'(4 + i), 16'(10 + i));
    exp = new[4];
    for (int i = 0; i < 4; i++) exp[i] = 16'(10 + i);
    do_read("burst4", 14'd4, 5'd4, exp, 4);

    // Address wrap
    do_write(14'd16383, 16'hAAAA);
    do_write(14'd0, 16'h5555);
    exp = new[2];
    exp[0] = 16'hAAAA;
    exp[1] = 16'h5555;
    do_read("wrap", 14'd16383, 5'd2, exp, 2);

    // Clear wins over a simultaneous write
    @(negedge clk);
    clr_start = 1'b1;
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_a     = 14'd3;
    req_d     = 16'd7;
    #1 check("clr ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 clr_start = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 20000) begin
      cnt++;
      @(negedge clk);
    end
    check("clr busy cycles", 32'(cnt), 32'd16384);
    exp = new[1];
    exp[0] = 16'd0;
    do_read("clr addr3", 14'd3, 5'd1, exp, 1);
    do_read("clr addr1", 14'd1, 5'd1, exp, 1);

    // Reset during beat 2 of an 8-beat read
    for (int i = 0; i < 8; i++) do_write(14'(20 + i), 16'(100 + i));
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_a     = 14'd20;
    req_len   = 5'd8;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort valid[%0d]", k), 32'(rsp_valid), 32'd1);
      check($sformatf("abort q[%0d]", k), 32'(rsp_q), 32'(100 + k));
    end
    #1 rst_n = 1'b0;
    #1 check("abort valid drop", 32'(rsp_valid), 32'd0);
    check("abort busy drop", 32'(busy), 32'd0);
    @(negedge clk);
    check("abort rst valid", 32'(rsp_valid), 32'd0);
    check("abort rst q", 32'(rsp_q), 32'd0);
    check("abort rst ready", 32'(req_ready), 32'd1);
    // Release and present a LEN=0 read right away
    #2 rst_n = 1'b1;
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_a     = 14'd21;
    req_len   = 5'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("len0 valid", 32'(rsp_valid), 32'd1);
    check("len0 q", 32'(rsp_q), 32'd101);
    check("len0 last", 32'(rsp_last), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("len0 quiet[%0d]", k), 32'(rsp_valid), 32'd0);
    end
    check("len0 q hold", 32'(rsp_q), 32'd101);
    check("len0 busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_burst.md
IMEM_BURST -- requirements
Module: imem_burst

Interface
REQ-001 Parameter DW, default 16, data word width in bits.
REQ-002 Parameter AW, default 14, address width; depth is 2^AW words.
REQ-003 Parameter LW, default 5, burst-length field width; the maximum burst is 2^LW-1 beats.
REQ-004 CLK  in  1  single clock; all state changes on its rising edge.
REQ-005 RSTN  in  1  asynchronous, active-low reset.
REQ-006 REQ_VALID  in  1  a request is presented.
REQ-007 REQ_READY  out  1  a request is accepted this cycle when both REQ_VALID and REQ_READY are 1.
REQ-008 REQ_WEN  in  1  active-low write select: 0 = single write, 1 = burst read.
REQ-009 REQ_A  in  AW  start address.
REQ-010 REQ_D  in  DW  write data.
REQ-011 REQ_LEN  in  LW  read burst length in beats; 0 is treated as 1.
REQ-012 CLR_START  in  1  one-cycle pulse that starts a zero-fill of the whole array.
REQ-013 RSP_VALID  out  1  RSP_Q holds valid read data this cycle.
REQ-014 RSP_Q  out  DW  read data.
REQ-015 RSP_LAST  out  1  marks the final beat of a burst.
REQ-016 BUSY  out  1  asserted while the block is in READ or CLEAR.

Function
REQ-017 The block SHALL contain a 2^AW x DW array with no reset of its contents.
REQ-018 The FSM SHALL have three states: IDLE, READ and CLEAR.
REQ-019 REQ_READY SHALL be 1 only when the state is IDLE and CLR_START is 0 (combinational).
REQ-020 An accepted write SHALL update mem[REQ_A] at that edge; the state stays IDLE and no response is produced.
REQ-021 An accepted read SHALL latch REQ_A and the effective length N, and move to READ.
- The beat k response (k = 0..N-1) is mem[REQ_A+k mod 2^AW].
- RSP_VALID for beat 0 is asserted the cycle after acceptance.
- Beats follow on consecutive cycles; there is no response backpressure.
REQ-022 The READ address SHALL wrap from 2^AW-1 to 0.
REQ-023 RSP_LAST SHALL be 1 only together with RSP_VALID on beat N-1; the FSM returns to IDLE on that edge.
REQ-024 The next request SHALL be accepted no earlier than the cycle after RSP_LAST, because REQ_READY is 0 during READ.
REQ-025 If CLR_START = 1 in IDLE, the FSM SHALL enter CLEAR, and any simultaneous REQ_VALID SHALL NOT be accepted.
REQ-026 CLEAR SHALL write 0 to addresses 0..2^AW-1, one per cycle in ascending order, then return to IDLE; a full clear takes exactly 2^AW cycles.
REQ-027 CLR_START SHALL be ignored outside IDLE.
REQ-028 RSP_Q SHALL hold its last value when RSP_VALID = 0; it has no meaning outside RSP_VALID.
REQ-029 Address and beat counters SHALL be AW and LW bits wide and SHALL NOT overflow into other state.

Reset
REQ-030 While RSTN = 0, the block SHALL hold these values:
- state = IDLE
- REQ_READY = 1 (subject to CLR_START)
- RSP_VALID = 0, RSP_LAST = 0, BUSY = 0
- RSP_Q = 0
- all counters = 0
REQ-031 Reset asserted mid-READ SHALL abort the burst immediately; no further beats are produced.
REQ-032 Reset asserted mid-CLEAR SHALL abort the clear; already-cleared words stay 0 and the rest keep their contents.
REQ-033 The first request after reset release SHALL be acceptable on the first rising edge with RSTN = 1.

Structure
REQ-034 The state encoding (IDLE/READ/CLEAR) and the default values of DW, AW and LW SHALL live in the shared package imem_pkg.
REQ-035 The storage array SHALL be a separate sub-module, imem_array, with ports CLK, CEN, WEN, A, D and Q.
- CEN and WEN are active-low.
- Q is registered with 1-cycle latency.
- imem_burst drives CEN/WEN from its FSM.

Verification
REQ-036 Write 350 to address 1, then read LEN=1 at address 1 -> RSP_VALID one cycle after acceptance with RSP_Q=350 and RSP_LAST=1.
REQ-037 Write values 10,11,12,13 to addresses 4..7, then read LEN=4 at address 4 -> four consecutive beats 10,11,12,13, with RSP_LAST only on the beat of 13.
REQ-038 Write 0xAAAA to address 16383 and 0x5555 to address 0, then read LEN=2 at address 16383 -> beats 0xAAAA then 0x5555 (wrap-around).
REQ-039 Pulse CLR_START together with REQ_VALID (write 7 to address 3) -> the write is not accepted and BUSY is high for 16384 cycles; after that, a read of address 3 returns 0.
REQ-040 Assert RSTN=0 during beat 2 of a LEN=8 read -> RSP_VALID drops immediately and no more beats occur; after release, REQ_READY=1 and a LEN=0 read returns exactly one beat.
